// File: rtl/target_tx.sv
// rtl/target_tx.sv - HDR-DDR target transmit serializer, one SDA bit per SCL edge
// Optional internal CRC5 generator: define TARGET_TX_CRC_GEN_EN
`timescale 1ns/1ps
module target_tx #(
  parameter int         DATA_W   = 8,
  parameter int         CRC_W    = 5,
  parameter logic [3:0] TOKEN    = 4'hC,
  parameter logic       SDA_IDLE = 1'b1
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_sclgen_scl_pos_edge,
  input  logic              i_sclgen_scl_neg_edge,
  input  logic              i_ddrccc_tx_en,
  input  logic [3:0]        i_ddrccc_tx_mode,
  input  logic              i_ddrccc_tx_pre,
  input  logic [DATA_W-1:0] i_regf_tx_data,
  input  logic [CRC_W-1:0]  i_crc_value,
  output logic              o_sdahnd_tx_sda,
  output logic              o_regf_rd_en,
  output logic              o_ddrccc_tx_mode_done,
  output logic              o_ddrccc_error_flag
);

  localparam int         CNT_W     = $clog2(DATA_W + 1);
  localparam logic [3:0] MODE_PRE  = 4'b0001;
  localparam logic [3:0] MODE_DATA = 4'b0010;
  localparam logic [3:0] MODE_PAR  = 4'b0100;
  localparam logic [3:0] MODE_TOK  = 4'b0101;
  localparam logic [3:0] MODE_CRC  = 4'b0110;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic                sda_q, sda_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tog_q, tog_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic [DATA_W-1:0]   d1_q, d1_d;
  logic [DATA_W-1:0]   d2_q, d2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   pat_new;
  logic [CNT_W-1:0]    len_new;
  logic                legal;
  logic                accept;
  logic                strobe;
  logic [CRC_W-1:0]    crc_src;
  logic [2*DATA_W-1:0] d_word;
  logic                pa1, pa0;

  assign strobe = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
  assign accept = (state_q == ST_IDLE) && i_ddrccc_tx_en && !i_sys_rst;
  assign d_word = {d1_q, d2_q};

  // Odd-index bits feed PA1, even-index bits feed the inverted PA0.
  always_comb begin
    pa1 = 1'b0;
    pa0 = 1'b1;
    for (int i = 0; i < 2 * DATA_W; i++) begin
      if (i % 2 == 1) pa1 = pa1 ^ d_word[i];
      else            pa0 = pa0 ^ d_word[i];
    end
  end

  // Patterns are left-aligned so the MSB is always the next bit out.
  always_comb begin
    pat_new = '0;
    len_new = '0;
    legal   = 1'b1;
    case (i_ddrccc_tx_mode)
      MODE_PRE: begin
        pat_new = {i_ddrccc_tx_pre, {(DATA_W-1){1'b0}}};
        len_new = CNT_W'(1);
      end
      MODE_DATA: begin
        pat_new = i_regf_tx_data;
        len_new = CNT_W'(DATA_W);
      end
      MODE_PAR: begin
        pat_new = {pa1, pa0, {(DATA_W-2){1'b0}}};
        len_new = CNT_W'(2);
        legal   = !tog_q;
      end
      MODE_TOK: begin
        pat_new = {TOKEN, {(DATA_W-4){1'b0}}};
        len_new = CNT_W'(4);
      end
      MODE_CRC: begin
        pat_new = {crc_src, {(DATA_W-CRC_W){1'b0}}};
        len_new = CNT_W'(CRC_W);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sda_d        = sda_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    tog_d        = tog_q;
    pat_d        = pat_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    o_regf_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (i_ddrccc_tx_mode == MODE_DATA) begin
            o_regf_rd_en = 1'b1;
            if (tog_q) d2_d = i_regf_tx_data;
            else       d1_d = i_regf_tx_data;
            tog_d = !tog_q;
          end
          if (i_ddrccc_tx_mode == MODE_PAR) tog_d = 1'b0;
          if (legal) begin
            sda_d   = pat_new[DATA_W-1];
            pat_d   = pat_new << 1;
            cnt_d   = CNT_W'(1);
            len_d   = len_new;
            state_d = ST_SHIFT;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (!i_ddrccc_tx_en) begin
          sda_d   = SDA_IDLE;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (strobe) begin
          if (cnt_q == len_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            sda_d = pat_q[DATA_W-1];
            pat_d = pat_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
      sda_q   <= SDA_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tog_q   <= 1'b0;
      pat_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sda_q   <= sda_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tog_q   <= tog_d;
      pat_q   <= pat_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

`ifdef TARGET_TX_CRC_GEN_EN
  localparam logic [CRC_W-1:0] CRC_SEED = 5'h1F;
  localparam logic [CRC_W-1:0] CRC_POLY = 5'h05;

  logic [CRC_W-1:0] crc_q, crc_d;
  logic             mode_data_q, mode_data_d;
  logic             mode_crc_q, mode_crc_d;
  logic             unused_crc_value;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    return {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? CRC_POLY : '0);
  endfunction

  assign crc_src          = crc_q;
  assign unused_crc_value = ^i_crc_value;

  // The CRC follows every data bit as it is driven, including bits of an aborted byte.
  always_comb begin
    crc_d       = crc_q;
    mode_data_d = mode_data_q;
    mode_crc_d  = mode_crc_q;
    if (accept) begin
      mode_data_d = (i_ddrccc_tx_mode == MODE_DATA);
      mode_crc_d  = (i_ddrccc_tx_mode == MODE_CRC);
      if (i_ddrccc_tx_mode == MODE_DATA) crc_d = crc_step(crc_q, i_regf_tx_data[DATA_W-1]);
    end else if (state_q == ST_SHIFT && i_ddrccc_tx_en && strobe) begin
      if (cnt_q == len_q) begin
        if (mode_crc_q) crc_d = CRC_SEED;
      end else if (mode_data_q) begin
        crc_d = crc_step(crc_q, pat_q[DATA_W-1]);
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      crc_q       <= CRC_SEED;
      mode_data_q <= 1'b0;
      mode_crc_q  <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      mode_data_q <= mode_data_d;
      mode_crc_q  <= mode_crc_d;
    end
  end
`else
  assign crc_src = i_crc_value;
`endif

  assign o_sdahnd_tx_sda       = sda_q;
  assign o_ddrccc_tx_mode_done = done_q;
  assign o_ddrccc_error_flag   = err_q;

endmodule
